// File: rtl/fuzzifier_t_seq_if.sv
// Handshake and config bus for fuzzifier_t_seq.
// Groups: sample in (in_valid/in_ready/x), mu out
// (out_valid/out_ready/mu_*), config (cfg_* write/commit/status).
// slave = the fuzzifier, master = sample source / consumer / host.
interface fuzzifier_t_seq_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       mu_neg;
    logic [15:0]       mu_zero;
    logic [15:0]       mu_pos;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic signed [7:0] cfg_wdata;
    logic              cfg_commit;
    logic              cfg_pending;
    logic              cfg_err;

    modport slave (
        input  in_valid, x, out_ready,
        input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        output in_ready, out_valid,
        output mu_neg, mu_zero, mu_pos,
        output cfg_pending, cfg_err
    );

    modport master (
        output in_valid, x, out_ready,
        output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
        input  in_ready, out_valid,
        input  mu_neg, mu_zero, mu_pos,
        input  cfg_pending, cfg_err
    );
endinterface

// File: rtl/fuzzifier_t_seq.sv
// Sequenced T-input fuzzifier: one shared trapezoid evaluated over
// neg/zero/pos parameter sets held in shadow/active register banks.
// Ports: clk, rst_n (async active-low), bus (fuzzifier_t_seq_if.slave):
//   x in (valid/ready), mu_neg/mu_zero/mu_pos Q1.15 out (valid/ready),
//   cfg_we/cfg_addr/cfg_wdata shadow write, cfg_commit, cfg_pending, cfg_err.
// Param SKIP_IDLE: 1 lets DONE accept the next x directly.
// Macro FUZZ_T_SEQ_CFG_CHECK_EN: reject commits with a set not a<=b<=c<=d.
module fuzzifier_t_seq #(
    parameter bit SKIP_IDLE = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    fuzzifier_t_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG,
        S_ZERO,
        S_POS,
        S_DONE
    } state_t;

    localparam logic signed [7:0] DFLT [12] = '{
        8'sh80, 8'sh80, 8'shC0, 8'sh00,
        8'shC0, 8'sh00, 8'sh00, 8'sh40,
        8'sh00, 8'sh40, 8'sh7F, 8'sh7F
    };

    state_t            r_state;
    state_t            w_state_nxt;
    logic signed [7:0] r_x;
    logic [15:0]       r_mu_neg;
    logic [15:0]       r_mu_zero;
    logic [15:0]       r_mu_pos;
    logic signed [7:0] r_shd [12];
    logic signed [7:0] r_act [12];
    logic              r_pending;
    logic              r_err;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_apply;
    logic              w_cfg_ok;
    logic              w_bad_addr;
    logic signed [7:0] w_shd_nxt [12];
    logic signed [7:0] w_a;
    logic signed [7:0] w_b;
    logic signed [7:0] w_c;
    logic signed [7:0] w_d;
    logic [8:0]        w_xa;
    logic [8:0]        w_ba;
    logic [8:0]        w_dx;
    logic [8:0]        w_dc;
    logic [8:0]        w_num;
    logic [8:0]        w_den;
    logic [23:0]       w_prod;
    logic [15:0]       w_mu;

    // Pending commit blocks new samples so the copy lands in IDLE.
    assign w_in_ready = rst_n && !r_pending &&
                        ((r_state == S_IDLE) ||
                         (SKIP_IDLE && (r_state == S_DONE) &&
                          bus.out_ready));
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = (r_state == S_DONE) && bus.out_ready;
    assign w_apply    = (r_state == S_IDLE) && r_pending;
    assign w_bad_addr = bus.cfg_we && (bus.cfg_addr >= 4'd12);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_in_fire) w_state_nxt = S_NEG;
            S_NEG:  w_state_nxt = S_ZERO;
            S_ZERO: w_state_nxt = S_POS;
            S_POS:  w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_out_fire)
                    w_state_nxt = w_in_fire ? S_NEG : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Same-cycle write is forwarded so a commit always sees it.
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            w_shd_nxt[i] = r_shd[i];
            if (bus.cfg_we && (bus.cfg_addr == 4'(i)))
                w_shd_nxt[i] = bus.cfg_wdata;
        end
    end

`ifdef FUZZ_T_SEQ_CFG_CHECK_EN
    always_comb begin
        w_cfg_ok = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if ((w_shd_nxt[4*s]   > w_shd_nxt[4*s+1]) ||
                (w_shd_nxt[4*s+1] > w_shd_nxt[4*s+2]) ||
                (w_shd_nxt[4*s+2] > w_shd_nxt[4*s+3]))
                w_cfg_ok = 1'b0;
        end
    end
`else
    assign w_cfg_ok = 1'b1;
`endif

    always_comb begin
        w_a = r_act[0];
        w_b = r_act[1];
        w_c = r_act[2];
        w_d = r_act[3];
        unique case (r_state)
            S_ZERO: begin
                w_a = r_act[4];
                w_b = r_act[5];
                w_c = r_act[6];
                w_d = r_act[7];
            end
            S_POS: begin
                w_a = r_act[8];
                w_b = r_act[9];
                w_c = r_act[10];
                w_d = r_act[11];
            end
            default: ;
        endcase
    end

    // 9-bit differences; only read where they are known positive.
    assign w_xa = {r_x[7], r_x} - {w_a[7], w_a};
    assign w_ba = {w_b[7], w_b} - {w_a[7], w_a};
    assign w_dx = {w_d[7], w_d} - {r_x[7], r_x};
    assign w_dc = {w_d[7], w_d} - {w_c[7], w_c};

    // Trapezoid: plateau checked before the ramps so a==b or c==d
    // at the edge still gives full membership.
    always_comb begin
        w_mu   = 16'h0000;
        w_num  = 9'd0;
        w_den  = 9'd0;
        w_prod = 24'd0;
        if ((r_x < w_a) || (r_x > w_d)) begin
            w_mu = 16'h0000;
        end else if ((r_x >= w_b) && (r_x <= w_c)) begin
            w_mu = 16'h7FFF;
        end else begin
            if (r_x < w_b) begin
                w_num = w_xa;
                w_den = w_ba;
            end else begin
                w_num = w_dx;
                w_den = w_dc;
            end
            w_prod = 24'(w_num) * 24'd32767;
            if (w_den != 9'd0)
                w_mu = 16'(w_prod / 24'(w_den));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= 8'sh00;
            r_mu_neg  <= 16'h0000;
            r_mu_zero <= 16'h0000;
            r_mu_pos  <= 16'h0000;
        end else begin
            if (w_in_fire)          r_x       <= bus.x;
            if (r_state == S_NEG)   r_mu_neg  <= w_mu;
            if (r_state == S_ZERO)  r_mu_zero <= w_mu;
            if (r_state == S_POS)   r_mu_pos  <= w_mu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) begin
                r_shd[i] <= DFLT[i];
                r_act[i] <= DFLT[i];
            end
        end else begin
            for (int i = 0; i < 12; i++) begin
                r_shd[i] <= w_shd_nxt[i];
                if (w_apply && w_cfg_ok)
                    r_act[i] <= w_shd_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_apply)              r_pending <= 1'b0;
            else if (bus.cfg_commit)  r_pending <= 1'b1;
            if (w_bad_addr)                r_err <= 1'b1;
            if (w_apply && !w_cfg_ok)      r_err <= 1'b1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.mu_neg      = r_mu_neg;
    assign bus.mu_zero     = r_mu_zero;
    assign bus.mu_pos      = r_mu_pos;
    assign bus.cfg_pending = r_pending;
    assign bus.cfg_err     = r_err;

endmodule
